fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter DATA_W, default 32, datapath width.
REQ-003 Parameter DEPTH, default 3, tracked pipeline stages after issue (legal 2..8).
REQ-004 Parameter LOAD_LAT, default 1, stages before load data is forwardable (legal 1..DEPTH-1).
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 iss_valid  in  1  decode stage presents an instruction.
REQ-008 iss_rs, iss_rt  in  REG_AW  source register addresses.
REQ-009 iss_rs_use, iss_rt_use  in  1  source actually read.
REQ-010 iss_wr  in  1  instruction writes a register; iss_rd  in  REG_AW  its destination.
REQ-011 iss_load  in  1  instruction is a load.
REQ-012 flush  in  1  taken branch/jump, squash younger work.
REQ-013 stg_data  in  DEPTH*DATA_W  result bus; slice k-1 holds stage-k result.
REQ-014 iss_ready  out  1  instruction accepted this cycle (0 = stall).
REQ-015 fwd_sel0, fwd_sel1  out  $clog2(DEPTH+1)  0 = register file, k = stage k.
REQ-016 fwd_data0, fwd_data1  out  DATA_W  selected forwarded value (0 when sel = 0).
REQ-017 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-018 Scoreboard SHALL hold DEPTH entries {valid, rd, load}, entry k = instruction k cycles past issue.
REQ-019 Each edge entries SHALL shift k -> k+1; entry DEPTH retires and is dropped.
REQ-020 Entry 1 SHALL load {1, iss_rd, iss_load} when iss_valid && iss_ready && iss_wr && iss_rd != 0, else a bubble (valid=0).
REQ-021 Per used source, the youngest valid entry with rd == source SHALL be the match; source 0 never matches.
REQ-022 Match at stage k is available if !load, or if load and k > LOAD_LAT; available -> fwd_sel = k, fwd_data = stg_data slice k-1.
REQ-023 Unavailable match on any used source SHALL drive iss_ready = 0 combinationally, same cycle.
REQ-024 No match -> fwd_sel = 0; selects and data SHALL be combinational from current state and issue inputs.
REQ-025 FSM states RUN, STALL, FLUSH; reset state RUN.
REQ-026 RUN -> STALL when iss_valid && !iss_ready; STALL -> RUN when the hazard clears; any state -> FLUSH on flush.
REQ-027 flush SHALL invalidate entries 1 and 2 at the next edge (the shift is overridden); flush overrides a simultaneous issue, which is not accepted.
REQ-028 FLUSH SHALL force iss_ready = 0 for exactly one cycle, then go to RUN.
REQ-029 flush while in FLUSH SHALL restart the one-cycle FLUSH.
REQ-030 stall_cnt SHALL increment each cycle iss_valid && !iss_ready; flush_cnt on each flush; both saturate at 16'hFFFF.

Reset
REQ-031 rst SHALL clear all entries, set FSM to RUN, and zero both counters.
REQ-032 After rst, iss_ready = 1 and fwd_sel0/1 = 0.
REQ-033 rst mid-stall or mid-flush SHALL take effect at that edge and win over every other input.

Configuration
REQ-034 Macro FWD_PERF_CNT_EN defined: stall_cnt/flush_cnt implemented per REQ-030.
REQ-035 Macro FWD_PERF_CNT_EN undefined: counters absent, outputs tied to 0, ports retained.

Structure
REQ-036 Package fwd_pkg SHALL hold the entry typedef, FSM state enum, and the select-width function.
REQ-037 Sub-module fwd_match (one operand's priority matcher and availability check) SHALL be instantiated twice.

Verification
REQ-038 Reset: rst=1 for 2 cycles -> iss_ready=1, fwd_sel0=fwd_sel1=0, counters 0.
REQ-039 Issue add r3, next cycle issue rs=r3 with stg_data slice 0 = 32'h1234 -> fwd_sel0=1, fwd_data0=32'h1234, iss_ready=1.
REQ-040 Issue lw r4 (LOAD_LAT=1), next cycle issue rs=r4 -> iss_ready=0 one cycle, stall_cnt=1, then fwd_sel0=2.
REQ-041 Write r0, then read rs=r0 -> fwd_sel0=0, no stall.
REQ-042 Writers of r5 at stages 2 and 1, issue rt=r5 -> fwd_sel1=1 (youngest).
REQ-043 flush asserted during the REQ-040 stall -> entries 1 and 2 cleared, iss_ready=0 one FLUSH cycle, FSM back to RUN, flush_cnt=1.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and helpers for the forwarding scoreboard.
//   fwd_entry_t    - one scoreboard slot {valid, rd, load}
//   fwd_state_t    - issue-control FSM states
//   fwd_sel_width  - width of a forwarding select for a given depth
// Destination addresses are stored zero-extended to FWD_RD_W bits, so
// REG_AW may be at most FWD_RD_W.
package fwd_pkg;

    localparam int FWD_RD_W = 8;

    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                load;
    } fwd_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } fwd_state_t;

    // Select 0 means register file, 1..depth means a pipeline stage.
    function automatic int fwd_sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority matcher for one source operand.
// Finds the youngest valid scoreboard entry whose destination equals the
// source and decides whether its result can be forwarded yet.
// Ports:
//   src, src_use - source register address and "operand is read" flag
//   ents         - scoreboard, ents[k-1] is the instruction k cycles past issue
//   stg_data     - per-stage results, slice k-1 belongs to stage k
//   sel, data    - forwarding select (0 = register file) and forwarded value
//   hazard       - youngest match is a load whose data is not ready yet
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic [REG_AW-1:0]               src,
    input  logic                            src_use,
    input  fwd_entry_t [DEPTH-1:0]          ents,
    input  logic [DEPTH*DATA_W-1:0]         stg_data,
    output logic [fwd_sel_width(DEPTH)-1:0] sel,
    output logic [DATA_W-1:0]               data,
    output logic                            hazard
);

    localparam int SEL_W = fwd_sel_width(DEPTH);

    logic found;

    // Scan from youngest (stage 1) to oldest; the first hit shadows any
    // older writer of the same register. r0 is hardwired and never matches.
    always_comb begin
        sel    = '0;
        data   = '0;
        hazard = 1'b0;
        found  = 1'b0;
        if (src_use && (src != '0)) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found && ents[k-1].valid &&
                    (ents[k-1].rd == FWD_RD_W'(src))) begin
                    found = 1'b1;
                    if (!ents[k-1].load || (k > LOAD_LAT)) begin
                        sel  = SEL_W'(k);
                        data = stg_data[(k-1)*DATA_W +: DATA_W];
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: register-hazard scoreboard with operand forwarding.
// Tracks the destinations of the last DEPTH issued instructions, steers
// both source operands to the youngest in-flight producer, stalls issue
// while a load result is not yet forwardable, and squashes the two
// youngest slots on a flush.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   iss_*                    - decode-stage instruction presented for issue
//   flush                    - taken branch/jump, squash younger work
//   stg_data                 - per-stage results, slice k-1 = stage k
//   iss_ready                - instruction accepted this cycle
//   fwd_sel0/1, fwd_data0/1  - forwarding select and value, rs and rt
//   stall_cnt, flush_cnt     - saturating performance counters
//
// Build option: define FWD_PERF_CNT_EN to implement the performance
// counters; otherwise they read as zero.
//
// FSM states:
//   state    | meaning
//   ST_RUN   | normal issue
//   ST_STALL | issue held by an unavailable load result
//   ST_FLUSH | one-cycle issue blackout after a flush
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            iss_valid,
    input  logic [REG_AW-1:0]               iss_rs,
    input  logic [REG_AW-1:0]               iss_rt,
    input  logic                            iss_rs_use,
    input  logic                            iss_rt_use,
    input  logic                            iss_wr,
    input  logic [REG_AW-1:0]               iss_rd,
    input  logic                            iss_load,
    input  logic                            flush,
    input  logic [DEPTH*DATA_W-1:0]         stg_data,
    output logic                            iss_ready,
    output logic [fwd_sel_width(DEPTH)-1:0] fwd_sel0,
    output logic [fwd_sel_width(DEPTH)-1:0] fwd_sel1,
    output logic [DATA_W-1:0]               fwd_data0,
    output logic [DATA_W-1:0]               fwd_data1,
    output logic [15:0]                     stall_cnt,
    output logic [15:0]                     flush_cnt
);

    fwd_entry_t [DEPTH-1:0] ents;
    fwd_entry_t [DEPTH-1:0] ents_nxt;
    fwd_entry_t             ent_new;
    fwd_state_t             state;
    fwd_state_t             state_nxt;
    logic                   hz0;
    logic                   hz1;
    logic                   hazard;
    logic                   issue_wr;

    fwd_match #(
        .REG_AW   (REG_AW),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) u_match0 (
        .src      (iss_rs),
        .src_use  (iss_rs_use),
        .ents     (ents),
        .stg_data (stg_data),
        .sel      (fwd_sel0),
        .data     (fwd_data0),
        .hazard   (hz0)
    );

    fwd_match #(
        .REG_AW   (REG_AW),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) u_match1 (
        .src      (iss_rt),
        .src_use  (iss_rt_use),
        .ents     (ents),
        .stg_data (stg_data),
        .sel      (fwd_sel1),
        .data     (fwd_data1),
        .hazard   (hz1)
    );

    assign hazard = hz0 | hz1;

    // A flush in the same cycle wins over the issue, so the instruction is
    // reported as not accepted.
    assign iss_ready = (state != ST_FLUSH) && !flush && !hazard;

    assign issue_wr = iss_valid && iss_ready && iss_wr && (iss_rd != '0);

    always_comb begin
        ent_new       = '0;
        ent_new.valid = issue_wr;
        ent_new.rd    = issue_wr ? FWD_RD_W'(iss_rd) : '0;
        ent_new.load  = issue_wr && iss_load;
    end

    // Older slots keep shifting on a flush; only the two youngest slots
    // belong to the squashed path and are dropped.
    always_comb begin
        ents_nxt = '0;
        for (int k = 1; k < DEPTH; k++) begin
            ents_nxt[k] = ents[k-1];
        end
        if (flush) begin
            ents_nxt[0] = '0;
            ents_nxt[1] = '0;
        end else begin
            ents_nxt[0] = ent_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ents <= '0;
        end else begin
            ents <= ents_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_RUN:   if (iss_valid && !iss_ready) state_nxt = ST_STALL;
                ST_STALL: if (!(iss_valid && hazard))  state_nxt = ST_RUN;
                ST_FLUSH: state_nxt = ST_RUN;
                default:  state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (iss_valid && !iss_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard with default parameters (REG_AW=5, DATA_W=32,
// DEPTH=3, LOAD_LAT=1). Each record is one cycle: inputs plus the outputs
// expected in that cycle, before the next rising edge.
module tb_fwd_scoreboard;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 3;
    localparam int SEL_W  = 2;
`ifdef FWD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [DATA_W-1:0] S1 = 32'h0000_1234;
    localparam logic [DATA_W-1:0] S2 = 32'h0000_2222;
    localparam logic [DATA_W-1:0] S3 = 32'h0000_3333;

    typedef struct {
        bit               rst;
        bit               v;
        logic [REG_AW-1:0] rs;
        bit               rsu;
        logic [REG_AW-1:0] rt;
        bit               rtu;
        bit               wr;
        logic [REG_AW-1:0] rd;
        bit               ld;
        bit               fl;
        bit               chk;
        bit               rdy;
        logic [SEL_W-1:0] s0;
        logic [SEL_W-1:0] s1;
        logic [15:0]      sc;
        logic [15:0]      fc;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    iss_valid = 1'b0;
    logic [REG_AW-1:0]       iss_rs = '0;
    logic [REG_AW-1:0]       iss_rt = '0;
    logic                    iss_rs_use = 1'b0;
    logic                    iss_rt_use = 1'b0;
    logic                    iss_wr = 1'b0;
    logic [REG_AW-1:0]       iss_rd = '0;
    logic                    iss_load = 1'b0;
    logic                    flush = 1'b0;
    logic [DEPTH*DATA_W-1:0] stg_data;
    logic                    iss_ready;
    logic [SEL_W-1:0]        fwd_sel0;
    logic [SEL_W-1:0]        fwd_sel1;
    logic [DATA_W-1:0]       fwd_data0;
    logic [DATA_W-1:0]       fwd_data1;
    logic [15:0]             stall_cnt;
    logic [15:0]             flush_cnt;

    int   n_vec = 0;
    int   n_miss = 0;
    int   idx = 0;
    vec_t exp_q[$];
    vec_t tbl[26];

    assign stg_data = {S3, S2, S1};

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .REG_AW   (REG_AW),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .LOAD_LAT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_rs     (iss_rs),
        .iss_rt     (iss_rt),
        .iss_rs_use (iss_rs_use),
        .iss_rt_use (iss_rt_use),
        .iss_wr     (iss_wr),
        .iss_rd     (iss_rd),
        .iss_load   (iss_load),
        .flush      (flush),
        .stg_data   (stg_data),
        .iss_ready  (iss_ready),
        .fwd_sel0   (fwd_sel0),
        .fwd_sel1   (fwd_sel1),
        .fwd_data0  (fwd_data0),
        .fwd_data1  (fwd_data1),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    function automatic vec_t mk(input int r, v, rs, rsu, rt, rtu, wr, rd, ld, fl,
                                input int rdy, s0, s1, sc, fc);
        vec_t t;
        t.rst = bit'(r);    t.v   = bit'(v);
        t.rs  = REG_AW'(rs); t.rsu = bit'(rsu);
        t.rt  = REG_AW'(rt); t.rtu = bit'(rtu);
        t.wr  = bit'(wr);   t.rd  = REG_AW'(rd);
        t.ld  = bit'(ld);   t.fl  = bit'(fl);
        t.chk = 1'b1;
        t.rdy = bit'(rdy);
        t.s0  = SEL_W'(s0); t.s1 = SEL_W'(s1);
        t.sc  = PERF ? 16'(sc) : 16'd0;
        t.fc  = PERF ? 16'(fc) : 16'd0;
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] sel_data(input logic [SEL_W-1:0] s);
        case (s)
            2'd1:    return S1;
            2'd2:    return S2;
            2'd3:    return S3;
            default: return '0;
        endcase
    endfunction

    task automatic cmp(input string name, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got %h expected %h", n, name, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard: queue empty at vec %0d", idx);
            return;
        end
        e = exp_q.pop_front();
        if (e.chk) begin
            n_vec++;
            cmp("iss_ready", idx, 32'(iss_ready), 32'(e.rdy));
            cmp("fwd_sel0",  idx, 32'(fwd_sel0),  32'(e.s0));
            cmp("fwd_sel1",  idx, 32'(fwd_sel1),  32'(e.s1));
            cmp("fwd_data0", idx, fwd_data0,      sel_data(e.s0));
            cmp("fwd_data1", idx, fwd_data1,      sel_data(e.s1));
            cmp("stall_cnt", idx, 32'(stall_cnt), 32'(e.sc));
            cmp("flush_cnt", idx, 32'(flush_cnt), 32'(e.fc));
        end
        idx++;
    endtask

    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        rst        = t.rst;
        iss_valid  = t.v;
        iss_rs     = t.rs;
        iss_rs_use = t.rsu;
        iss_rt     = t.rt;
        iss_rt_use = t.rtu;
        iss_wr     = t.wr;
        iss_rd     = t.rd;
        iss_load   = t.ld;
        flush      = t.fl;
        exp_q.push_back(t);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        //            rst v rs rsu rt rtu wr rd ld fl | rdy s0 s1 sc fc
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        tbl[0].chk = 1'b0;
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        // add r3, then read r3 from stage 1, then from stage 2
        tbl[2]  = mk(0, 1, 1, 1, 2, 1, 1, 3, 0, 0,  1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 3, 1, 0, 0, 1, 4, 1, 0,  1, 2, 0, 0, 0);
        // lw r4 consumer: one stall cycle, then forward from stage 2
        tbl[5]  = mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0,  1, 2, 0, 1, 0);
        // write r0 then read r0
        tbl[7]  = mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0);
        tbl[8]  = mk(0, 1, 0, 1, 0, 1, 1, 5, 0, 0,  1, 0, 0, 1, 0);
        // two writers of r5; unused rt ignored; youngest wins; aging
        tbl[9]  = mk(0, 1, 0, 0, 5, 0, 1, 5, 0, 0,  1, 0, 0, 1, 0);
        tbl[10] = mk(0, 1, 5, 0, 5, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0);
        tbl[11] = mk(0, 1, 5, 1, 5, 1, 0, 0, 0, 0,  1, 2, 2, 1, 0);
        tbl[12] = mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 3, 0, 1, 0);
        // load hazard with flush in the stall cycle
        tbl[13] = mk(0, 1, 0, 0, 0, 0, 1, 4, 1, 0,  1, 0, 0, 1, 0);
        tbl[14] = mk(0, 1, 4, 1, 0, 0, 1, 6, 0, 1,  0, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 4, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 1);
        tbl[16] = mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 1);
        // flush with issue, flush again while in FLUSH
        tbl[17] = mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 1,  0, 0, 0, 2, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3, 2);
        tbl[19] = mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 3);
        tbl[20] = mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 4, 3);
        // flush keeps the stage-2 producer, drops stage-1
        tbl[21] = mk(0, 1, 0, 0, 0, 0, 1, 8, 0, 0,  1, 0, 0, 4, 3);
        tbl[22] = mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0,  1, 0, 0, 4, 3);
        tbl[23] = mk(0, 0, 8, 1, 0, 0, 0, 0, 0, 1,  0, 2, 0, 4, 3);
        tbl[24] = mk(0, 0, 8, 1, 9, 1, 0, 0, 0, 0,  0, 3, 0, 4, 4);
        tbl[25] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 4, 4);

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i]);
        end

        // reset in STALL with a simultaneous flush: reset wins
        apply(mk(0, 1, 0, 0, 0, 0, 1, 10, 1, 0,  1, 0, 0, 4, 4));
        apply(mk(0, 1, 10, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, 4));
        apply(mk(1, 1, 10, 1, 0, 0, 0, 0, 0, 1,  0, 2, 0, 5, 4));
        apply(mk(0, 1, 10, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));

        // reset in FLUSH
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));

        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard: %0d entries left unchecked", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
